// File: rtl/imem_responder.sv
// Small synchronous FIFO used to queue row requests.
// Latency: data written on a push is visible at the head the next cycle.
// Backpressure: full is raised at DEPTH entries; a push while full needs a pop in the same cycle.
module imem_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop_rdy && !empty;
    assign do_push = push_vld && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Input-feature-map memory: kicks one row to every PPE, serves row requests, then broadcasts timestep-done.
// Latency: first packet the cycle after start; a served request is presented one cycle after its FIFO pop.
// Backpressure: out_data holds while out_ready is low; in_ready drops when the request FIFO is full.
module imem_responder #(
    parameter int IFMAP_SIZE  = 25,
    parameter int NUM_ROWS    = 25,
    parameter int NUM_PE      = 5,
    parameter int PE_BASE_ID  = 0,
    parameter int ROWS_PER_PE = 5,
    parameter int IMEM_ID     = 10,
    parameter int REQ_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4:0]            base_row,
    input  logic                  wr_en,
    input  logic [4:0]            wr_addr,
    input  logic [IFMAP_SIZE-1:0] wr_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IFMAP_SIZE+7:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IFMAP_SIZE+7:0] out_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int CW = $clog2(ROWS_PER_PE + 1);
    localparam int KW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam logic [3:0] OP_INPUT = 4'd1;
    localparam logic [3:0] OP_TIMESTEP_DONE = 4'd15;

    typedef struct packed {
        logic [3:0]            dest;
        logic [3:0]            opcode;
        logic [IFMAP_SIZE-1:0] dat;
    } pkt_t;

    typedef enum logic [2:0] {S_IDLE, S_KICK, S_SERVE, S_FLUSH, S_DONE} state_t;

    state_t                state;
    logic [IFMAP_SIZE-1:0] mem [NUM_ROWS];
    logic [4:0]            base_q;
    logic [CW-1:0]         cnt [NUM_PE];
    logic [KW-1:0]         pe_idx;
    logic [KW-1:0]         nxt_idx;
    pkt_t                  out_pkt;

    logic                  req_push_vld;
    logic                  req_pop_rdy;
    logic [7:0]            req_head_dat;
    logic                  req_full;
    logic                  req_empty;
    logic [3:0]            head_dest;
    logic [3:0]            head_id;
    logic [KW-1:0]         head_k;
    logic                  req_ok;
    logic                  all_done;
    logic                  wr_ok;
    logic                  wr_illegal;
    logic                  unused_in_bits;

    assign out_data       = out_pkt;
    assign busy           = (state != S_IDLE);
    assign in_ready       = (state != S_IDLE) && !req_full;
    assign req_push_vld   = in_valid && in_ready;
    assign req_pop_rdy    = (state == S_SERVE) && !out_valid && !req_empty;
    assign nxt_idx        = pe_idx + 1'b1;
    assign unused_in_bits = ^in_data[IFMAP_SIZE-1:0];

    assign wr_ok      = wr_en && !reset && (state == S_IDLE) && (int'(wr_addr) < NUM_ROWS);
    assign wr_illegal = wr_en && ((state != S_IDLE) || (int'(wr_addr) >= NUM_ROWS));

    // Only dest and requester ID matter, so the payload field is not queued.
    imem_fifo #(.WIDTH(8), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (req_push_vld),
        .push_dat (in_data[IFMAP_SIZE+7 -: 8]),
        .pop_rdy  (req_pop_rdy),
        .pop_dat  (req_head_dat),
        .full     (req_full),
        .empty    (req_empty)
    );

    assign head_dest = req_head_dat[7:4];
    assign head_id   = req_head_dat[3:0];
    assign head_k    = KW'(int'(head_id) - PE_BASE_ID);

    always_comb begin
        req_ok = (int'(head_dest) == IMEM_ID) && (int'(head_id) >= PE_BASE_ID)
              && (int'(head_id) < PE_BASE_ID + NUM_PE);
        if (req_ok && (int'(cnt[head_k]) >= ROWS_PER_PE)) req_ok = 1'b0;
    end

    always_comb begin
        all_done = 1'b1;
        for (int k = 0; k < NUM_PE; k++) begin
            if (int'(cnt[k]) != ROWS_PER_PE) all_done = 1'b0;
        end
    end

    // Rows past the end of memory read as zero rather than wrapping.
    function automatic logic [IFMAP_SIZE-1:0] row_data(input logic [4:0] base, input int k, input int j);
        int r;
        r = int'(base) + k + j;
        if (r < NUM_ROWS) return mem[r[4:0]];
        return '0;
    endfunction

    function automatic pkt_t mk_pkt(input int k, input logic [3:0] op, input logic [IFMAP_SIZE-1:0] d);
        pkt_t p;
        p.dest   = 4'(PE_BASE_ID + k);
        p.opcode = op;
        p.dat    = d;
        return p;
    endfunction

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            base_q    <= '0;
            pe_idx    <= '0;
            out_valid <= 1'b0;
            out_pkt   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            for (int k = 0; k < NUM_PE; k++) cnt[k] <= '0;
        end else begin
            done <= 1'b0;
            err  <= wr_illegal;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_KICK;
                        base_q    <= base_row;
                        pe_idx    <= '0;
                        for (int k = 0; k < NUM_PE; k++) cnt[k] <= '0;
                        cnt[0]    <= CW'(1);
                        out_valid <= 1'b1;
                        out_pkt   <= mk_pkt(0, OP_INPUT, row_data(base_row, 0, 0));
                    end
                end
                S_KICK: begin
                    if (out_valid && out_ready) begin
                        if (int'(pe_idx) == NUM_PE - 1) begin
                            out_valid <= 1'b0;
                            state     <= S_SERVE;
                        end else begin
                            pe_idx       <= nxt_idx;
                            cnt[nxt_idx] <= CW'(1);
                            out_pkt      <= mk_pkt(int'(nxt_idx), OP_INPUT,
                                                   row_data(base_q, int'(nxt_idx), 0));
                        end
                    end
                end
                S_SERVE: begin
                    if (out_valid && out_ready) out_valid <= 1'b0;
                    if (req_pop_rdy) begin
                        if (req_ok) begin
                            out_valid   <= 1'b1;
                            out_pkt     <= mk_pkt(int'(head_k), OP_INPUT,
                                                  row_data(base_q, int'(head_k), int'(cnt[head_k])));
                            cnt[head_k] <= cnt[head_k] + 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (!out_valid && req_empty && all_done) begin
                        state     <= S_FLUSH;
                        pe_idx    <= '0;
                        out_valid <= 1'b1;
                        out_pkt   <= mk_pkt(0, OP_TIMESTEP_DONE, '0);
                    end
                end
                S_FLUSH: begin
                    if (out_valid && out_ready) begin
                        if (int'(pe_idx) == NUM_PE - 1) begin
                            out_valid <= 1'b0;
                            state     <= S_DONE;
                            done      <= 1'b1;
                        end else begin
                            pe_idx  <= nxt_idx;
                            out_pkt <= mk_pkt(int'(nxt_idx), OP_TIMESTEP_DONE, '0);
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: expected packets queued at stimulus time, compared on each output transfer.
module tb_imem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  base_row;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [24:0] wr_data;
    logic        in_valid;
    logic        in_ready;
    logic [32:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [32:0] out_data;
    logic        busy;
    logic        done;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    int          err_cnt = 0;
    int          exp_err = 0;
    logic [32:0] exp_q[$];
    logic [24:0] model_mem [25];
    int          model_cnt [5];
    int          model_base;
    logic        stall_q = 1'b0;
    logic [32:0] stall_dat = '0;

    imem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_row  (base_row),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [32:0] row_pkt(input int k, input int j);
        int r;
        logic [24:0] d;
        r = model_base + k + j;
        d = (r < 25) ? model_mem[5'(r)] : 25'd0;
        return {4'(k), 4'd1, d};
    endfunction

    function automatic bit model_all_done();
        for (int k = 0; k < 5; k++) if (model_cnt[k] < 5) return 1'b0;
        return 1'b1;
    endfunction

    task automatic monitor();
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_q = 1'b0;
            end else begin
                if (stall_q) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== stall_dat) begin
                        errors++;
                        $display("FAIL hold_stable: out_valid=%b out_data=%h, required 1 / %h",
                                 out_valid, out_data, stall_dat);
                    end
                end
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_pkt: out_data=%h, required no packet", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_data !== e) begin
                            errors++;
                            $display("FAIL pkt: out_data=%h, required %h", out_data, e);
                        end
                    end
                end
                if (err === 1'b1) err_cnt++;
                stall_q   = (out_valid === 1'b1) && (out_ready !== 1'b1);
                stall_dat = out_data;
            end
        end
    endtask

    task automatic start_ts(input int b);
        model_base = b;
        for (int k = 0; k < 5; k++) begin
            model_cnt[k] = 1;
            exp_q.push_back(row_pkt(k, 0));
        end
        base_row = 5'(b);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_req(input logic [3:0] dest, input logic [3:0] id);
        int  n;
        bit  ok;
        ok = 1'b0;
        if (dest == 4'd10 && id < 4'd5) begin
            if (model_cnt[id[2:0]] < 5) ok = 1'b1;
        end
        if (ok) begin
            exp_q.push_back(row_pkt(int'(id), model_cnt[id[2:0]]));
            model_cnt[id[2:0]]++;
            if (model_all_done()) begin
                for (int k = 0; k < 5; k++) exp_q.push_back({4'(k), 4'd15, 25'd0});
            end
        end else begin
            exp_err++;
        end
        in_valid = 1'b1;
        in_data  = {dest, id, 25'd0};
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            n++;
            if (n >= 1000) begin
                checks++;
                errors++;
                $display("FAIL req_accept: in_ready=%b after %0d cycles, required 1", in_ready, n);
                break;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d packets outstanding, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_done();
        int n;
        for (int j = 0; j < 5; j++)
            for (int k = 0; k < 5; k++)
                if (model_cnt[k] < 5) send_req(4'd10, 4'(k));
        n = 0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) break;
            n++;
            if (n >= 2000) begin
                checks++;
                errors++;
                $display("FAIL done_timeout: done=%b, required a pulse", done);
                break;
            end
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_at_done: busy=%b, required 1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL after_done: busy=%b done=%b, required 0/0", busy, done);
        end
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL ts_packets: %0d outstanding, required 0", exp_q.size());
        end
        checks++;
        if (err_cnt != exp_err) begin
            errors++;
            $display("FAIL err_count: got %0d, required %0d", err_cnt, exp_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 33'd0 || in_ready !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ov=%b od=%h ir=%b busy=%b done=%b err=%b, required all 0",
                     out_valid, out_data, in_ready, busy, done, err);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_mem();
        for (int i = 0; i < 25; i++) begin
            wr_en   = 1'b1;
            wr_addr = 5'(i);
            wr_data = 25'(i * 32'h10101);
            model_mem[i] = 25'(i * 32'h10101);
            @(posedge clk);
            #1;
        end
        wr_addr = 5'd25;
        wr_data = 25'h1FFFFFF;
        exp_err++;
        @(posedge clk);
        #1 wr_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (err_cnt != exp_err) begin
            errors++;
            $display("FAIL wr_addr_range_err: err count %0d, required %0d", err_cnt, exp_err);
        end
    endtask

    task automatic test_kickoff();
        out_ready = 1'b1;
        start_ts(0);
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL kick_latency: out_valid=%b busy=%b, required 1/1", out_valid, busy);
        end
        wait_drain();
    endtask

    task automatic test_full_timestep();
        run_to_done();
    endtask

    task automatic test_backpressure();
        logic [32:0] first_pkt;
        out_ready = 1'b0;
        start_ts(0);
        first_pkt = row_pkt(0, 0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== first_pkt) begin
            errors++;
            $display("FAIL bp_first: ov=%b od=%h, required 1 / %h", out_valid, out_data, first_pkt);
        end
        for (int k = 0; k < 4; k++) send_req(4'd10, 4'(k));
        in_valid = 1'b1;
        in_data  = {4'd10, 4'd4, 25'd0};
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL fifo_full_ready: in_ready=%b, required 0", in_ready);
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        checks++;
        if (out_data !== first_pkt) begin
            errors++;
            $display("FAIL bp_hold: out_data=%h, required %h", out_data, first_pkt);
        end
        out_ready = 1'b1;
        run_to_done();
    endtask

    task automatic test_illegal_req();
        out_ready = 1'b1;
        start_ts(0);
        wait_drain();
        send_req(4'd3, 4'd0);
        send_req(4'd10, 4'd7);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || err_cnt != exp_err) begin
            errors++;
            $display("FAIL bad_req: out_valid=%b err count %0d, required 0 / %0d", out_valid, err_cnt, exp_err);
        end
        for (int i = 0; i < 5; i++) send_req(4'd10, 4'd0);
        wait_drain();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (err_cnt != exp_err) begin
            errors++;
            $display("FAIL quota_err: err count %0d, required %0d", err_cnt, exp_err);
        end
        run_to_done();
    endtask

    task automatic test_wr_busy();
        out_ready = 1'b1;
        start_ts(0);
        wr_en   = 1'b1;
        wr_addr = 5'd3;
        wr_data = 25'h1ABCDEF;
        exp_err++;
        @(posedge clk);
        #1 wr_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (err_cnt != exp_err) begin
            errors++;
            $display("FAIL wr_busy_err: err count %0d, required %0d", err_cnt, exp_err);
        end
        run_to_done();
    endtask

    task automatic test_edge_rows();
        out_ready = 1'b1;
        start_ts(21);
        run_to_done();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        start_ts(0);
        wait_drain();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_req(4'd10, 4'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: ov=%b busy=%b ir=%b, required 0/0/0", out_valid, busy, in_ready);
        end
        reset = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
        start_ts(0);
        run_to_done();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        base_row = '0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        model_base = 0;
        for (int k = 0; k < 5; k++) model_cnt[k] = 0;
        fork
            monitor();
        join_none
        test_reset();
        test_load_mem();
        test_kickoff();
        test_full_timestep();
        test_backpressure();
        test_illegal_req();
        test_wr_busy();
        test_edge_rows();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
